// File: rtl/line_fifo_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | line_fifo_scheduler: row/col FIFO loader and row/col pass sequencer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module line_fifo_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  parse_write,
  input  logic [DATA_WIDTH-1:0] parse_line,
  input  logic                  parse_row,
  input  logic                  parsed,
  input  logic                  solve_rd_req,
  output logic                  solve_rd_vld,
  output logic [DATA_WIDTH-1:0] solve_rd_data,
  input  logic                  solve_wr,
  input  logic [DATA_WIDTH-1:0] solve_wr_data,
  input  logic                  solved,
  output logic                  pass_row,
  output logic                  pass_done,
  output logic                  no_progress,
  output logic                  overflow,
  output logic [1:0]            state,
  output logic [DATA_WIDTH-1:0] fr_din,
  output logic [DATA_WIDTH-1:0] fc_din,
  output logic                  fr_wr,
  output logic                  fc_wr,
  output logic                  fr_rd,
  output logic                  fc_rd,
  input  logic [DATA_WIDTH-1:0] fr_dout,
  input  logic [DATA_WIDTH-1:0] fc_dout,
  input  logic                  fr_full,
  input  logic                  fc_full,
  input  logic                  fr_empty,
  input  logic                  fc_empty,
  output logic                  fifo_srst
);

  localparam int c_CW = $clog2(DEPTH + 1);
  localparam int c_TW = c_CW + 1;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ROW   = 2'd1,
    ST_COL   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_CW-1:0]   r_cnt_r, r_cnt_c, r_remaining;
  logic [c_CW-1:0]   w_cnt_r_nxt, w_cnt_c_nxt;
  logic [c_TW-1:0]   r_rd_tally, r_pb_tally, w_rd_tally_nxt, w_pb_tally_nxt;
  logic              r_rd_vld, r_rd_row, r_no_progress, r_overflow;
  logic              w_load, w_in_pass, w_row_act, w_col_act, w_pass_end;
  logic              w_fr_wr_req, w_fc_wr_req, w_rd_ok, w_rd, w_drop, w_pass_entry;

  always_comb begin
    w_load      = !rst && (r_state == ST_LOAD);
    w_in_pass   = (r_state == ST_ROW) || (r_state == ST_COL);
    w_row_act   = !rst && (r_state == ST_ROW);
    w_col_act   = !rst && (r_state == ST_COL);
    // A pass may only end once the last requested word has been delivered
    w_pass_end  = w_in_pass && (r_remaining == '0) && !r_rd_vld;

    w_fr_wr_req = (w_load && parse_write && parse_row)  || (w_row_act && solve_wr);
    w_fc_wr_req = (w_load && parse_write && !parse_row) || (w_col_act && solve_wr);
    fr_wr       = w_fr_wr_req && !fr_full;
    fc_wr       = w_fc_wr_req && !fc_full;
    w_drop      = (w_fr_wr_req && fr_full) || (w_fc_wr_req && fc_full);
    fr_din      = w_load ? parse_line : solve_wr_data;
    fc_din      = w_load ? parse_line : solve_wr_data;

    w_rd_ok     = solve_rd_req && (r_remaining != '0);
    fr_rd       = w_row_act && w_rd_ok && !fr_empty;
    fc_rd       = w_col_act && w_rd_ok && !fc_empty;
    w_rd        = fr_rd || fc_rd;

    w_cnt_r_nxt     = r_cnt_r + c_CW'(fr_wr) - c_CW'(fr_rd);
    w_cnt_c_nxt     = r_cnt_c + c_CW'(fc_wr) - c_CW'(fc_rd);
    w_rd_tally_nxt  = r_rd_tally + c_TW'(w_rd);
    w_pb_tally_nxt  = r_pb_tally + c_TW'(w_in_pass && solve_wr);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_LOAD:  if (parsed) w_state_nxt = ST_ROW;
      ST_ROW:   if (solved) w_state_nxt = ST_FLUSH;
                else if (w_pass_end) w_state_nxt = ST_COL;
      ST_COL:   if (solved) w_state_nxt = ST_FLUSH;
                else if (w_pass_end) w_state_nxt = ST_ROW;
      ST_FLUSH: w_state_nxt = ST_LOAD;
      default:  w_state_nxt = ST_LOAD;
    endcase
    w_pass_entry = (w_state_nxt != r_state) &&
                   ((w_state_nxt == ST_ROW) || (w_state_nxt == ST_COL));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_LOAD;
      r_cnt_r       <= '0;
      r_cnt_c       <= '0;
      r_remaining   <= '0;
      r_rd_tally    <= '0;
      r_pb_tally    <= '0;
      r_rd_vld      <= 1'b0;
      r_rd_row      <= 1'b0;
      r_no_progress <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt == ST_FLUSH) || (r_state == ST_FLUSH)) begin
        r_cnt_r     <= '0;
        r_cnt_c     <= '0;
        r_remaining <= '0;
        r_rd_vld    <= 1'b0;
        r_rd_row    <= 1'b0;
      end else begin
        r_cnt_r  <= w_cnt_r_nxt;
        r_cnt_c  <= w_cnt_c_nxt;
        r_rd_vld <= w_rd;
        r_rd_row <= fr_rd;
        // Snapshot includes a write landing on the entry edge (e.g. with parsed)
        if (w_pass_entry)
          r_remaining <= (w_state_nxt == ST_ROW) ? w_cnt_r_nxt : w_cnt_c_nxt;
        else if (w_rd)
          r_remaining <= r_remaining - c_CW'(1);
      end

      if ((r_state == ST_COL) && (w_state_nxt == ST_ROW) &&
          (w_rd_tally_nxt != '0) && (w_pb_tally_nxt == w_rd_tally_nxt))
        r_no_progress <= 1'b1;

      if (w_pass_entry && (w_state_nxt == ST_ROW)) begin
        r_rd_tally <= '0;
        r_pb_tally <= '0;
      end else begin
        r_rd_tally <= w_rd_tally_nxt;
        r_pb_tally <= w_pb_tally_nxt;
      end

      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign state         = r_state;
  assign pass_row      = rst || (r_state != ST_COL);
  assign pass_done     = w_pass_end && !rst && !solved;
  assign no_progress   = r_no_progress;
  assign overflow      = r_overflow;
  assign solve_rd_vld  = r_rd_vld;
  assign solve_rd_data = r_rd_row ? fr_dout : fc_dout;
  assign fifo_srst     = rst || (r_state == ST_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_line_fifo_scheduler.sv
`default_nettype none
// Directed bench for line_fifo_scheduler with behavioural row/col FIFO models.
module tb_line_fifo_scheduler;

  localparam int c_DW    = 16;
  localparam int c_DEPTH = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            parse_write = 1'b0, parse_row = 1'b0, parsed = 1'b0;
  logic [c_DW-1:0] parse_line = '0;
  logic            solve_rd_req = 1'b0, solve_wr = 1'b0, solved = 1'b0;
  logic [c_DW-1:0] solve_wr_data = '0;
  logic            solve_rd_vld, pass_row, pass_done, no_progress, overflow, fifo_srst;
  logic [c_DW-1:0] solve_rd_data, fr_din, fc_din;
  logic [c_DW-1:0] fr_dout = '0, fc_dout = '0;
  logic [1:0]      state;
  logic            fr_wr, fc_wr, fr_rd, fc_rd, fr_full, fc_full, fr_empty, fc_empty;

  int n_checks = 0;
  int n_fails  = 0;

  line_fifo_scheduler #(.DATA_WIDTH(c_DW), .DEPTH(c_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .parse_write(parse_write), .parse_line(parse_line), .parse_row(parse_row),
    .parsed(parsed),
    .solve_rd_req(solve_rd_req), .solve_rd_vld(solve_rd_vld), .solve_rd_data(solve_rd_data),
    .solve_wr(solve_wr), .solve_wr_data(solve_wr_data), .solved(solved),
    .pass_row(pass_row), .pass_done(pass_done), .no_progress(no_progress),
    .overflow(overflow), .state(state),
    .fr_din(fr_din), .fc_din(fc_din), .fr_wr(fr_wr), .fc_wr(fc_wr),
    .fr_rd(fr_rd), .fc_rd(fc_rd), .fr_dout(fr_dout), .fc_dout(fc_dout),
    .fr_full(fr_full), .fc_full(fc_full), .fr_empty(fr_empty), .fc_empty(fc_empty),
    .fifo_srst(fifo_srst)
  );

  always #10 clk = ~clk;

  // Standard-mode FIFO models: 1-cycle read latency, sync reset
  logic [c_DW-1:0] mem_r [c_DEPTH];
  logic [c_DW-1:0] mem_c [c_DEPTH];
  int wp_r = 0, rp_r = 0, n_r = 0;
  int wp_c = 0, rp_c = 0, n_c = 0;

  assign fr_full  = (n_r == c_DEPTH);
  assign fr_empty = (n_r == 0);
  assign fc_full  = (n_c == c_DEPTH);
  assign fc_empty = (n_c == 0);

  always @(posedge clk) begin
    if (fifo_srst) begin
      wp_r <= 0; rp_r <= 0; n_r <= 0; fr_dout <= '0;
    end else begin
      if (fr_wr && n_r < c_DEPTH) begin
        mem_r[wp_r] <= fr_din;
        wp_r <= (wp_r + 1) % c_DEPTH;
      end
      if (fr_rd && n_r > 0) begin
        fr_dout <= mem_r[rp_r];
        rp_r <= (rp_r + 1) % c_DEPTH;
      end
      n_r <= n_r + ((fr_wr && n_r < c_DEPTH) ? 1 : 0) - ((fr_rd && n_r > 0) ? 1 : 0);
    end
  end

  always @(posedge clk) begin
    if (fifo_srst) begin
      wp_c <= 0; rp_c <= 0; n_c <= 0; fc_dout <= '0;
    end else begin
      if (fc_wr && n_c < c_DEPTH) begin
        mem_c[wp_c] <= fc_din;
        wp_c <= (wp_c + 1) % c_DEPTH;
      end
      if (fc_rd && n_c > 0) begin
        fc_dout <= mem_c[rp_c];
        rp_c <= (rp_c + 1) % c_DEPTH;
      end
      n_c <= n_c + ((fc_wr && n_c < c_DEPTH) ? 1 : 0) - ((fc_rd && n_c > 0) ? 1 : 0);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [c_DW-1:0] exp_row [3];
  int  n_vld;
  bit  saw_done;

  initial begin
    exp_row[0] = 16'h1001; exp_row[1] = 16'h1002; exp_row[2] = 16'h1003;

    // Reset
    @(negedge clk);
    check_val("rst_fifo_srst", fifo_srst, 1);
    check_val("rst_pass_row", pass_row, 1);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    check_val("rst_state", state, 0);
    check_val("rst_overflow", overflow, 0);
    check_val("rst_no_progress", no_progress, 0);
    check_val("rst_rd_vld", solve_rd_vld, 0);
    check_val("rst_cnt_r", dut.r_cnt_r, 0);
    check_val("rst_srst_low", fifo_srst, 0);

    // Load 3 row + 2 col words; last col word shares the cycle with parsed
    next_cyc();
    parse_write = 1'b1; parse_row = 1'b1; parse_line = 16'h1001;
    solve_rd_req = 1'b1; solve_wr = 1'b1;
    @(negedge clk);
    check_val("load_no_rd", {30'd0, fr_rd, fc_rd}, 0);
    check_val("load_pb_ignored", fc_wr, 0);
    next_cyc(); parse_line = 16'h1002; solve_rd_req = 1'b0; solve_wr = 1'b0;
    next_cyc(); parse_line = 16'h1003;
    next_cyc(); parse_row = 1'b0; parse_line = 16'h2001;
    next_cyc(); parse_line = 16'h2002; parsed = 1'b1;
    next_cyc(); parse_write = 1'b0; parsed = 1'b0; solve_rd_req = 1'b1;
    @(negedge clk);
    check_val("load_state_row", state, 1);
    check_val("load_cnt_r", dut.r_cnt_r, 3);
    check_val("load_cnt_c", dut.r_cnt_c, 2);
    check_val("row_remaining_start", dut.r_remaining, 3);

    // Row pass, rd_req held, no put-backs
    n_vld = 0; saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (solve_rd_vld) begin
        if (n_vld < 3) check_val("row_rd_data", solve_rd_data, exp_row[n_vld]);
        n_vld++;
      end
      if (pass_done) begin
        saw_done = 1'b1;
        break;
      end
    end
    check_val("row_pass_done_seen", saw_done, 1);
    check_val("row_rd_vld_count", n_vld, 3);
    next_cyc(); solve_rd_req = 1'b0;
    @(negedge clk);
    check_val("col_state", state, 2);
    check_val("col_remaining_start", dut.r_remaining, 2);
    check_val("col_pass_row", pass_row, 0);
    check_val("row_cnt_after_pass", dut.r_cnt_r, 0);

    // Col pass: read and put back in the same cycle
    next_cyc(); solve_rd_req = 1'b1; solve_wr = 1'b1; solve_wr_data = 16'h2AAA;
    next_cyc(); solve_wr_data = 16'h2BBB;
    @(negedge clk);
    check_val("rdwr_cnt_c_hold", dut.r_cnt_c, 2);
    check_val("rdwr_remaining", dut.r_remaining, 1);
    check_val("col_rd_data0", solve_rd_data, 16'h2001);
    next_cyc(); solve_rd_req = 1'b0; solve_wr = 1'b0;
    @(negedge clk);
    check_val("col_rd_data1", solve_rd_data, 16'h2002);
    check_val("col_done_waits_vld", pass_done, 0);
    next_cyc();
    @(negedge clk);
    check_val("col_pass_done", pass_done, 1);
    next_cyc();
    @(negedge clk);
    check_val("empty_row_state", state, 1);
    check_val("empty_row_done", pass_done, 1);
    check_val("progress_made", no_progress, 0);
    next_cyc();
    @(negedge clk);
    check_val("col2_remaining", dut.r_remaining, 2);

    // Round with every word put back, in swapped order
    next_cyc(); solve_rd_req = 1'b1; solve_wr = 1'b1; solve_wr_data = 16'h2BBB;
    next_cyc(); solve_wr_data = 16'h2AAA;
    @(negedge clk);
    check_val("col2_rd_data0", solve_rd_data, 16'h2AAA);
    next_cyc(); solve_rd_req = 1'b0; solve_wr = 1'b0;
    @(negedge clk);
    check_val("col2_rd_data1", solve_rd_data, 16'h2BBB);
    next_cyc();
    @(negedge clk);
    check_val("col2_pass_done", pass_done, 1);
    next_cyc();
    @(negedge clk);
    check_val("no_progress_set", no_progress, 1);
    next_cyc();
    @(negedge clk);
    check_val("col3_remaining", dut.r_remaining, 2);
    next_cyc(); solve_rd_req = 1'b1;
    next_cyc(); solve_rd_req = 1'b0; solved = 1'b1;
    @(negedge clk);
    check_val("putback_order", solve_rd_data, 16'h2BBB);
    next_cyc(); solved = 1'b0;
    @(negedge clk);
    check_val("flush_state", state, 3);
    check_val("flush_srst", fifo_srst, 1);
    check_val("flush_cnt_r", dut.r_cnt_r, 0);
    check_val("flush_cnt_c", dut.r_cnt_c, 0);
    next_cyc();
    @(negedge clk);
    check_val("post_flush_state", state, 0);
    check_val("post_flush_srst", fifo_srst, 0);

    // Fill row FIFO to DEPTH, then one put-back more
    parse_write = 1'b1; parse_row = 1'b1;
    for (int i = 0; i < c_DEPTH; i++) begin
      parse_line = 16'h3000 + 16'(i);
      parsed = (i == c_DEPTH - 1);
      next_cyc();
    end
    parsed = 1'b0; parse_row = 1'b0; parse_line = 16'h4444;
    solve_wr = 1'b1; solve_wr_data = 16'hDEAD;
    @(negedge clk);
    check_val("full_cnt_r", dut.r_cnt_r, c_DEPTH);
    check_val("full_no_wr", fr_wr, 0);
    check_val("pass_parse_ignored", fc_wr, 0);
    next_cyc(); solve_wr = 1'b0; parse_write = 1'b0;
    @(negedge clk);
    check_val("overflow_set", overflow, 1);
    check_val("ovf_cnt_r_hold", dut.r_cnt_r, c_DEPTH);
    check_val("ovf_cnt_c_hold", dut.r_cnt_c, 0);
    check_val("ovf_remaining", dut.r_remaining, c_DEPTH);

    // Reset pulse mid-pass
    next_cyc(); rst = 1'b1;
    @(negedge clk);
    check_val("midrst_srst", fifo_srst, 1);
    check_val("midrst_pass_row", pass_row, 1);
    next_cyc(); rst = 1'b0;
    @(negedge clk);
    check_val("midrst_state", state, 0);
    check_val("midrst_cnt_r", dut.r_cnt_r, 0);
    check_val("midrst_overflow", overflow, 0);
    check_val("midrst_no_progress", no_progress, 0);
    check_val("midrst_remaining", dut.r_remaining, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
